// File: rtl/gray_rd_arbiter_if.sv
// Bundle of the shared gray-image read port: the memory side plus both requester channels.
// The arbiter takes the master view; the requesters and the memory together take the slave view.
interface gray_rd_arbiter_if #(
   parameter int AW = 14,
   parameter int DW = 8
);
   logic          gray_ready;
   logic          m_gray_req;
   logic [AW-1:0] m_gray_addr;
   logic [DW-1:0] m_gray_data;

   logic          r0_req;
   logic [AW-1:0] r0_addr;
   logic          r0_lock;
   logic          r0_gnt;
   logic          r0_rvalid;
   logic [DW-1:0] r0_rdata;

   logic          r1_req;
   logic [AW-1:0] r1_addr;
   logic          r1_lock;
   logic          r1_gnt;
   logic          r1_rvalid;
   logic [DW-1:0] r1_rdata;

   logic          busy;

   modport master (
      input  gray_ready, m_gray_data,
      input  r0_req, r0_addr, r0_lock,
      input  r1_req, r1_addr, r1_lock,
      output m_gray_req, m_gray_addr,
      output r0_gnt, r0_rvalid, r0_rdata,
      output r1_gnt, r1_rvalid, r1_rdata,
      output busy
   );

   modport slave (
      output gray_ready, m_gray_data,
      output r0_req, r0_addr, r0_lock,
      output r1_req, r1_addr, r1_lock,
      input  m_gray_req, m_gray_addr,
      input  r0_gnt, r0_rvalid, r0_rdata,
      input  r1_gnt, r1_rvalid, r1_rdata,
      input  busy
   );
endinterface

// File: rtl/gray_rd_arbiter.sv
// Two-requester round-robin arbiter for the gray-image read port, with burst lock and a
// tag pipeline that steers each returned pixel back to the requester that issued it.
module gray_rd_arbiter #(
   parameter int AW        = 14,
   parameter int DW        = 8,
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 9
) (
   input  logic                clk,
   input  logic                reset,
   gray_rd_arbiter_if.master   bus
);
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_R0   = 2'd1,
      OWN_R1   = 2'd2
   } own_state_t;

   own_state_t    state, state_next;
   logic          rr, rr_next;
   logic [CW-1:0] burst_cnt, cnt_next;
   logic [RD_LAT:0] tag_vld, tag_id;
   logic          m_req_q;
   logic [AW-1:0] m_addr_q;

   logic [1:0]    req, lock;
   logic          owner_vld, owner_id, owner_act, force_off;
   logic          gnt_vld, gnt_id;
   logic [DW-1:0] rdata;

   assign req       = {bus.r1_req, bus.r0_req};
   assign lock      = {bus.r1_lock, bus.r0_lock};
   assign owner_vld = (state != OWN_NONE);
   assign owner_id  = (state == OWN_R1);
   assign owner_act = owner_vld && req[owner_id];
   assign force_off = owner_act && (burst_cnt == CW'(MAX_BURST)) && req[~owner_id];

   // Grant selection and ownership/round-robin bookkeeping; all state holds while memory stalls.
   always_comb begin
      gnt_vld    = 1'b0;
      gnt_id     = 1'b0;
      state_next = state;
      rr_next    = rr;
      cnt_next   = burst_cnt;
      if (bus.gray_ready && reset) begin
         if (owner_act && !force_off) begin
            gnt_vld = 1'b1;
            gnt_id  = owner_id;
         end else if (force_off) begin
            gnt_vld = 1'b1;
            gnt_id  = ~owner_id;
         end else if (req[rr]) begin
            gnt_vld = 1'b1;
            gnt_id  = rr;
         end else if (req[~rr]) begin
            gnt_vld = 1'b1;
            gnt_id  = ~rr;
         end

         if (gnt_vld) begin
            if (lock[gnt_id]) begin
               state_next = gnt_id ? OWN_R1 : OWN_R0;
               if (owner_vld && (owner_id == gnt_id))
                  cnt_next = (burst_cnt == CW'(MAX_BURST)) ? burst_cnt : burst_cnt + CW'(1);
               else
                  cnt_next = CW'(1);
               if (force_off)
                  rr_next = owner_id;
            end else begin
               state_next = OWN_NONE;
               cnt_next   = '0;
               rr_next    = ~gnt_id;
            end
         end else if (owner_vld && !req[owner_id]) begin
            state_next = OWN_NONE;
            cnt_next   = '0;
            rr_next    = ~owner_id;
         end
      end
   end

   // Arbitration state, the registered memory request and the {valid,id} return tags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= OWN_NONE;
         rr        <= 1'b0;
         burst_cnt <= '0;
         m_req_q   <= 1'b0;
         m_addr_q  <= '0;
         tag_vld   <= '0;
         tag_id    <= '0;
      end else begin
         state     <= state_next;
         rr        <= rr_next;
         burst_cnt <= cnt_next;
         m_req_q   <= gnt_vld;
         if (gnt_vld)
            m_addr_q <= gnt_id ? bus.r1_addr : bus.r0_addr;
         tag_vld   <= {tag_vld[RD_LAT-1:0], gnt_vld};
         tag_id    <= {tag_id[RD_LAT-1:0], gnt_id};
      end
   end

   assign rdata           = bus.m_gray_data;
   assign bus.m_gray_req  = m_req_q;
   assign bus.m_gray_addr = m_addr_q;
   assign bus.r0_gnt      = gnt_vld && !gnt_id;
   assign bus.r1_gnt      = gnt_vld && gnt_id;
   assign bus.r0_rvalid   = reset && tag_vld[RD_LAT] && !tag_id[RD_LAT];
   assign bus.r1_rvalid   = reset && tag_vld[RD_LAT] && tag_id[RD_LAT];
   assign bus.r0_rdata    = rdata;
   assign bus.r1_rdata    = rdata;
   assign bus.busy        = (|tag_vld) || gnt_vld;
endmodule
